// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares a single memory port between an instruction-cache refill requester
// (I-side, read-only, abortable by i_flush) and a data requester (D-side,
// read or write). Each accepted request is carried from grant to completion:
//   IDLE   -> pick a requester (round-robin when both are eligible)
//   BUSY_x -> hold mem_* steady until mem_ready
//   back to IDLE, pulsing x_done for one cycle with the captured read data.
//
// Every output comes straight from a flop.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-low reset
//   i_req      I-side request (held with i_addr until i_done or i_flush)
//   i_addr     I-side read address
//   i_flush    I-side abort; blocks a new grant, and suppresses i_done for an
//              I transaction already in flight
//   i_done     one-cycle completion pulse, i_rdata valid with it
//   i_rdata    I-side read data
//   d_req      D-side request (held with d_we/d_addr/d_wdata until d_done)
//   d_we       1 = write, 0 = read
//   d_addr     D-side address
//   d_wdata    D-side write data
//   d_done     one-cycle completion pulse, d_rdata valid with it on reads
//   d_rdata    D-side read data (only updated by reads)
//   mem_ce     memory request, held until mem_ready
//   mem_we     memory write enable
//   mem_addr   memory address
//   mem_wdata  memory write data
//   mem_ready  memory completion, looked at only while a transaction is open
//   mem_rdata  memory read data, valid with mem_ready
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // I-side
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_flush,
  output logic                  i_done,
  output logic [DATA_WIDTH-1:0] i_rdata,
  // D-side
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_done,
  output logic [DATA_WIDTH-1:0] d_rdata,
  // memory side
  output logic                  mem_ce,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t                  state_reg,      state_next;
  logic                    last_grant_reg, last_grant_next;
  logic                    kill_reg,       kill_next;
  logic                    mem_ce_reg,     mem_ce_next;
  logic                    mem_we_reg,     mem_we_next;
  logic [ADDR_WIDTH-1:0]   mem_addr_reg,   mem_addr_next;
  logic [DATA_WIDTH-1:0]   mem_wdata_reg,  mem_wdata_next;
  logic                    i_done_reg,     i_done_next;
  logic [DATA_WIDTH-1:0]   i_rdata_reg,    i_rdata_next;
  logic                    d_done_reg,     d_done_next;
  logic [DATA_WIDTH-1:0]   d_rdata_reg,    d_rdata_next;

  // A requester that is seeing its own done pulse is not yet allowed to
  // re-request: its req line still reflects the transaction that just ended.
  // A flushing I-side is never eligible.
  logic i_elig;
  logic d_elig;
  logic grant_i;
  logic grant_d;

  assign i_elig = i_req && !i_flush && !i_done_reg;
  assign d_elig = d_req && !d_done_reg;

  // When both are eligible, the side that did not win last time goes next.
  assign grant_d = d_elig && (!i_elig || (last_grant_reg == GRANT_I));
  assign grant_i = i_elig && !grant_d;

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= GRANT_I;
      kill_reg       <= 1'b0;
      mem_ce_reg     <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      i_done_reg     <= 1'b0;
      i_rdata_reg    <= '0;
      d_done_reg     <= 1'b0;
      d_rdata_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      kill_reg       <= kill_next;
      mem_ce_reg     <= mem_ce_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      i_done_reg     <= i_done_next;
      i_rdata_reg    <= i_rdata_next;
      d_done_reg     <= d_done_next;
      d_rdata_reg    <= d_rdata_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    kill_next       = kill_reg;
    mem_ce_next     = mem_ce_reg;
    mem_we_next     = mem_we_reg;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    i_done_next     = 1'b0;   // done strobes last exactly one cycle
    i_rdata_next    = i_rdata_reg;
    d_done_next     = 1'b0;
    d_rdata_next    = d_rdata_reg;

    case (state_reg)
      IDLE: begin
        // mem_ready is deliberately ignored here: no transaction is open.
        kill_next = 1'b0;
        if (grant_i) begin
          state_next      = BUSY_I;
          last_grant_next = GRANT_I;
          mem_ce_next     = 1'b1;
          mem_we_next     = 1'b0;
          mem_addr_next   = i_addr;
          mem_wdata_next  = '0;
        end else if (grant_d) begin
          state_next      = BUSY_D;
          last_grant_next = GRANT_D;
          mem_ce_next     = 1'b1;
          mem_we_next     = d_we;
          mem_addr_next   = d_addr;
          mem_wdata_next  = d_wdata;
        end
      end

      BUSY_I: begin
        // A flush cannot cancel the memory access already issued; it only
        // marks the result as unwanted.
        if (i_flush) begin
          kill_next = 1'b1;
        end
        if (mem_ready) begin
          state_next  = IDLE;
          kill_next   = 1'b0;
          mem_ce_next = 1'b0;
          mem_we_next = 1'b0;
          // A flush landing in the completion cycle is as good as an
          // earlier one.
          if (!kill_reg && !i_flush) begin
            i_done_next  = 1'b1;
            i_rdata_next = mem_rdata;
          end
        end
      end

      BUSY_D: begin
        if (mem_ready) begin
          state_next  = IDLE;
          mem_ce_next = 1'b0;
          mem_we_next = 1'b0;
          d_done_next = 1'b1;
          // Writes return nothing, so the last read value stays visible.
          if (!mem_we_reg) begin
            d_rdata_next = mem_rdata;
          end
        end
      end

      default: begin
        state_next  = IDLE;
        mem_ce_next = 1'b0;
        mem_we_next = 1'b0;
      end
    endcase
  end

  assign mem_ce    = mem_ce_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign i_done    = i_done_reg;
  assign i_rdata   = i_rdata_reg;
  assign d_done    = d_done_reg;
  assign d_rdata   = d_rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_flush = 1'b0;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_flush   (i_flush),
    .i_done    (i_done),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_done    (d_done),
    .d_rdata   (d_rdata),
    .mem_ce    (mem_ce),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Inputs of a row are driven during that cycle; expected outputs are what
  // the registered outputs show in that same cycle.
  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_flush;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        e_ce;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_idone;
    logic [31:0] e_irdata;
    logic        e_ddone;
    logic [31:0] e_drdata;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag, input logic [31:0] exp_irdata,
                                  input logic [31:0] exp_drdata);
    chk({tag, ".mem_ce"}, {31'd0, mem_ce}, 32'd0);
    chk({tag, ".i_done"}, {31'd0, i_done}, 32'd0);
    chk({tag, ".d_done"}, {31'd0, d_done}, 32'd0);
    chk({tag, ".i_rdata"}, i_rdata, exp_irdata);
    chk({tag, ".d_rdata"}, d_rdata, exp_drdata);
  endtask

  initial begin
    // --- table: single I read, then simultaneous requests ------------------
    //            ireq iaddr   ifl dreq dwe daddr  dwdata rdy rdata
    //            | ce we eaddr  ewdata idone irdata ddone drdata
    vecs[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 32'h0,        1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 32'h0,
                 1'b1, 1'b0, 32'h100, 32'h0,  1'b0, 32'h0,        1'b0, 32'h0};
    vecs[2]  = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 32'h0,
                 1'b1, 1'b0, 32'h100, 32'h0,  1'b0, 32'h0,        1'b0, 32'h0};
    vecs[3]  = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,  1'b1, 32'hDEADBEEF,
                 1'b1, 1'b0, 32'h100, 32'h0,  1'b0, 32'h0,        1'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0,   32'h0,  1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 32'h104, 1'b0, 1'b1, 1'b1, 32'h200, 32'h55, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 32'h104, 1'b0, 1'b1, 1'b1, 32'h200, 32'h55, 1'b1, 32'hAAAA,
                 1'b1, 1'b1, 32'h200, 32'h55, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
    // mem_ready high while mem_ce is low must be ignored
    vecs[7]  = '{1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,  1'b1, 32'hBBBB,
                 1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 32'hDEADBEEF, 1'b1, 32'h0};
    vecs[8]  = '{1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,  1'b1, 32'hCAFE0001,
                 1'b1, 1'b0, 32'h104, 32'h0,  1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0,   32'h0,  1'b1, 32'hCAFE0001, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 32'hCAFE0001, 1'b0, 32'h0};

    // --- reset state ---------------------------------------------------------
    repeat (2) @(posedge clk);
    #1;
    chk("reset.mem_ce", {31'd0, mem_ce}, 32'd0);
    chk("reset.mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset.mem_addr", mem_addr, 32'd0);
    chk("reset.mem_wdata", mem_wdata, 32'd0);
    chk("reset.i_done", {31'd0, i_done}, 32'd0);
    chk("reset.i_rdata", i_rdata, 32'd0);
    chk("reset.d_done", {31'd0, d_done}, 32'd0);
    chk("reset.d_rdata", d_rdata, 32'd0);
    $display("reset state checked");
    @(negedge clk);
    rst = 1'b1;

    // --- table-driven rows ---------------------------------------------------
    for (int r = 0; r < 11; r++) begin
      step();
      chk($sformatf("row%0d.mem_ce", r), {31'd0, mem_ce}, {31'd0, vecs[r].e_ce});
      if (vecs[r].e_ce) begin
        chk($sformatf("row%0d.mem_we", r), {31'd0, mem_we}, {31'd0, vecs[r].e_we});
        chk($sformatf("row%0d.mem_addr", r), mem_addr, vecs[r].e_addr);
        chk($sformatf("row%0d.mem_wdata", r), mem_wdata, vecs[r].e_wdata);
      end
      chk($sformatf("row%0d.i_done", r), {31'd0, i_done}, {31'd0, vecs[r].e_idone});
      chk($sformatf("row%0d.i_rdata", r), i_rdata, vecs[r].e_irdata);
      chk($sformatf("row%0d.d_done", r), {31'd0, d_done}, {31'd0, vecs[r].e_ddone});
      chk($sformatf("row%0d.d_rdata", r), d_rdata, vecs[r].e_drdata);
      $display("row %0d: ce=%0b addr=0x%08h i_done=%0b d_done=%0b", r, mem_ce, mem_addr,
               i_done, d_done);
      i_req     = vecs[r].i_req;
      i_addr    = vecs[r].i_addr;
      i_flush   = vecs[r].i_flush;
      d_req     = vecs[r].d_req;
      d_we      = vecs[r].d_we;
      d_addr    = vecs[r].d_addr;
      d_wdata   = vecs[r].d_wdata;
      mem_ready = vecs[r].mem_ready;
      mem_rdata = vecs[r].mem_rdata;
    end

    // --- round-robin: both requesters hold req, memory answers at once ------
    step();
    chk("rr.start.mem_ce", {31'd0, mem_ce}, 32'd0);
    i_req = 1'b1; i_addr = 32'h500;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    mem_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("rr%0d.mem_ce", k), {31'd0, mem_ce}, 32'd1);
      chk($sformatf("rr%0d.mem_addr", k), mem_addr, (k % 2 == 0) ? 32'h400 : 32'h500);
      mem_rdata = 32'h1000 + k;
      if (k == 5) d_req = 1'b0;
      step();
      chk($sformatf("rr%0d.d_done", k), {31'd0, d_done}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr%0d.i_done", k), {31'd0, i_done}, (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k % 2 == 0) chk($sformatf("rr%0d.d_rdata", k), d_rdata, 32'h1000 + k);
      else            chk($sformatf("rr%0d.i_rdata", k), i_rdata, 32'h1000 + k);
      $display("rr %0d: grant=%s done", k, (k % 2 == 0) ? "D" : "I");
    end
    i_req = 1'b0; mem_ready = 1'b0;

    // --- flush while BUSY_I, D pending -------------------------------------
    step();
    chk_idle_outputs("fl.idle", 32'h1005, 32'h1004);
    i_req = 1'b1; i_addr = 32'h300;
    step();
    chk("fl.mem_ce1", {31'd0, mem_ce}, 32'd1);
    chk("fl.mem_addr", mem_addr, 32'h300);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
    step();
    chk("fl.mem_ce2", {31'd0, mem_ce}, 32'd1);
    i_flush = 1'b1;
    step();
    chk("fl.mem_ce_held", {31'd0, mem_ce}, 32'd1);
    chk("fl.mem_addr_held", mem_addr, 32'h300);
    i_flush = 1'b0; i_req = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h1234;
    step();
    chk_idle_outputs("fl.after", 32'h1005, 32'h1004);
    mem_rdata = 32'h9999;
    step();
    chk("fl.d_grant.mem_ce", {31'd0, mem_ce}, 32'd1);
    chk("fl.d_grant.mem_addr", mem_addr, 32'h600);
    chk("fl.d_grant.mem_we", {31'd0, mem_we}, 32'd0);
    step();
    chk("fl.d_done", {31'd0, d_done}, 32'd1);
    chk("fl.d_rdata", d_rdata, 32'h9999);
    chk("fl.i_done", {31'd0, i_done}, 32'd0);
    d_req = 1'b0; mem_ready = 1'b0;
    $display("flush during BUSY_I sequence done");

    // --- flush coincident with mem_ready, then flush in IDLE ----------------
    step();
    chk("fc.idle.mem_ce", {31'd0, mem_ce}, 32'd0);
    i_req = 1'b1; i_addr = 32'h700;
    step();
    chk("fc.mem_ce", {31'd0, mem_ce}, 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'h7777; i_flush = 1'b1;
    step();
    chk_idle_outputs("fc.after", 32'h1005, 32'h9999);
    mem_ready = 1'b0;
    step();
    chk("fi.mem_ce1", {31'd0, mem_ce}, 32'd0);
    chk("fi.i_done1", {31'd0, i_done}, 32'd0);
    step();
    chk("fi.mem_ce2", {31'd0, mem_ce}, 32'd0);
    i_flush = 1'b0;
    step();
    chk("fi.regrant.mem_ce", {31'd0, mem_ce}, 32'd1);
    chk("fi.regrant.mem_addr", mem_addr, 32'h700);
    mem_ready = 1'b1; mem_rdata = 32'h7070;
    step();
    chk("fi.i_done", {31'd0, i_done}, 32'd1);
    chk("fi.i_rdata", i_rdata, 32'h7070);
    i_req = 1'b0; mem_ready = 1'b0;
    $display("flush coincident / flush in IDLE sequence done");

    // --- asynchronous reset in the middle of BUSY_D -------------------------
    step();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h800; d_wdata = 32'hABCD;
    step();
    chk("ar.mem_ce", {31'd0, mem_ce}, 32'd1);
    chk("ar.mem_we", {31'd0, mem_we}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar.rst.mem_ce", {31'd0, mem_ce}, 32'd0);
    chk("ar.rst.mem_we", {31'd0, mem_we}, 32'd0);
    chk("ar.rst.mem_addr", mem_addr, 32'd0);
    chk("ar.rst.mem_wdata", mem_wdata, 32'd0);
    chk("ar.rst.i_rdata", i_rdata, 32'd0);
    chk("ar.rst.d_rdata", d_rdata, 32'd0);
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
    chk_idle_outputs("ar.idle", 32'd0, 32'd0);
    i_req = 1'b1; i_addr = 32'h900;
    step();
    chk("ar.regrant.mem_ce", {31'd0, mem_ce}, 32'd1);
    chk("ar.regrant.mem_addr", mem_addr, 32'h900);
    mem_ready = 1'b1; mem_rdata = 32'h5A5A;
    step();
    chk("ar.i_done", {31'd0, i_done}, 32'd1);
    chk("ar.i_rdata", i_rdata, 32'h5A5A);
    i_req = 1'b0; mem_ready = 1'b0;
    $display("async reset sequence done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
